lin_sched: RTL and testbench

//  Schedule-table controller for the LIN commander. Sequences frame headers from a

---
 rtl/lin_sched.sv | 175 +++++++++++++++++
 tb/tb_lin_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lin_sched.sv
// LIN schedule-table controller: walks a programmable slot table, requests frame
// headers from the commander, waits for completion, times the inter-frame gap.
module lin_sched #(
    parameter int NUM_SLOTS = 8,
    parameter int GAP_W     = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                         sys_clk,
    input  logic                         rstn,
    input  logic                         enable,
    input  logic [$clog2(NUM_SLOTS)-1:0] last_slot,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr,
    input  logic                         cfg_valid,
    input  logic [5:0]                   cfg_pid,
    input  logic [GAP_W-1:0]             cfg_gap,
    input  logic                         lin_busy,
    input  logic                         comm_tx_done,
    input  logic                         resp_busy,
    output logic                         start,
    output logic [5:0]                   pid,
    output logic                         inter_tx_delay,
    output logic [$clog2(NUM_SLOTS)-1:0] cur_slot,
    output logic                         frame_done,
    output logic                         err_timeout,
    output logic [15:0]                  frame_cnt
);
    localparam int SW   = $clog2(NUM_SLOTS);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    // Watchdog counts from 0 in the first ISSUE cycle, so expiry lands TIMEOUT cycles after FETCH.
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT_DONE, S_WAIT_RESP, S_GAP
    } state_t;

    state_t            state_r, next_state_s;
    logic [SW-1:0]     cur_slot_r, eff_last_s, next_slot_s;
    logic [5:0]        pid_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [WD_W-1:0]   wd_r;
    logic              start_r, itd_r, frame_done_r, err_r;
    logic [15:0]       frame_cnt_r;
    logic              wd_active_s, wd_expire_s, frame_end_s;
    int                last_int_s;

    logic              tab_valid_r [NUM_SLOTS];
    logic [5:0]        tab_pid_r   [NUM_SLOTS];
    logic [GAP_W-1:0]  tab_gap_r   [NUM_SLOTS];

    // Clamp last_slot and compute the slot following the current one.
    always_comb begin
        last_int_s = int'(last_slot);
        if (last_int_s > NUM_SLOTS - 1) begin
            eff_last_s = SW'(NUM_SLOTS - 1);
        end else begin
            eff_last_s = last_slot;
        end
        if (cur_slot_r >= eff_last_s) begin
            next_slot_s = {SW{1'b0}};
        end else begin
            next_slot_s = cur_slot_r + SW'(1);
        end
    end

    // Next-state logic; the watchdog overrides every wait in the active states.
    always_comb begin
        next_state_s = state_r;
        frame_end_s  = 1'b0;
        wd_active_s  = (state_r == S_ISSUE) || (state_r == S_WAIT_DONE) || (state_r == S_WAIT_RESP);
        wd_expire_s  = wd_active_s && (wd_r == WD_LIMIT);
        case (state_r)
            S_IDLE: begin
                if (enable) next_state_s = S_FETCH;
                else        next_state_s = S_IDLE;
            end
            S_FETCH: begin
                if (tab_valid_r[cur_slot_r]) next_state_s = S_ISSUE;
                else                         next_state_s = S_GAP;
            end
            S_ISSUE: begin
                if (wd_expire_s)   next_state_s = S_GAP;
                else if (lin_busy) next_state_s = S_WAIT_DONE;
                else               next_state_s = S_ISSUE;
            end
            S_WAIT_DONE: begin
                if (wd_expire_s)       next_state_s = S_GAP;
                else if (comm_tx_done) next_state_s = S_WAIT_RESP;
                else                   next_state_s = S_WAIT_DONE;
            end
            S_WAIT_RESP: begin
                if (wd_expire_s) begin
                    next_state_s = S_GAP;
                end else if (!lin_busy && !resp_busy) begin
                    next_state_s = S_GAP;
                    frame_end_s  = 1'b1;
                end else begin
                    next_state_s = S_WAIT_RESP;
                end
            end
            S_GAP: begin
                if (gap_cnt_r != {GAP_W{1'b0}}) next_state_s = S_GAP;
                else if (enable)                next_state_s = S_FETCH;
                else                            next_state_s = S_IDLE;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Sequencer registers, registered outputs and datapath counters.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= S_IDLE;
            cur_slot_r   <= {SW{1'b0}};
            pid_r        <= 6'd0;
            gap_cnt_r    <= {GAP_W{1'b0}};
            wd_r         <= {WD_W{1'b0}};
            start_r      <= 1'b0;
            itd_r        <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else begin
            state_r      <= next_state_s;
            start_r      <= (next_state_s == S_ISSUE);
            itd_r        <= (next_state_s == S_GAP);
            frame_done_r <= frame_end_s;
            err_r        <= wd_expire_s;
            if (frame_end_s) frame_cnt_r <= frame_cnt_r + 16'd1;
            case (state_r)
                S_FETCH: begin
                    gap_cnt_r <= tab_gap_r[cur_slot_r];
                    wd_r      <= {WD_W{1'b0}};
                    if (tab_valid_r[cur_slot_r]) pid_r <= tab_pid_r[cur_slot_r];
                end
                S_ISSUE, S_WAIT_DONE, S_WAIT_RESP: begin
                    wd_r <= wd_r + WD_W'(1);
                end
                S_GAP: begin
                    if (gap_cnt_r != {GAP_W{1'b0}}) begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end else if (enable) begin
                        cur_slot_r <= next_slot_s;
                    end else begin
                        cur_slot_r <= {SW{1'b0}};
                    end
                end
                default: ;
            endcase
        end
    end

    // Schedule table; a write lands after any FETCH sampling the old entry on the same edge.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tab_valid_r[i] <= 1'b0;
                tab_pid_r[i]   <= 6'd0;
                tab_gap_r[i]   <= {GAP_W{1'b0}};
            end
        end else if (cfg_we && (int'(cfg_addr) < NUM_SLOTS)) begin
            tab_valid_r[cfg_addr] <= cfg_valid;
            tab_pid_r[cfg_addr]   <= cfg_pid;
            tab_gap_r[cfg_addr]   <= cfg_gap;
        end
    end

    assign start          = start_r;
    assign pid            = pid_r;
    assign inter_tx_delay = itd_r;
    assign cur_slot       = cur_slot_r;
    assign frame_done     = frame_done_r;
    assign err_timeout    = err_r;
    assign frame_cnt      = frame_cnt_r;
endmodule

// File: tb/tb_lin_sched.sv
// Directed bench for lin_sched: a default-timeout instance plus a TIMEOUT=64
// instance sharing the same stimulus for the watchdog scenario.
module tb_lin_sched;
    logic        sys_clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  last_slot = 3'd0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic        cfg_valid = 1'b0;
    logic [5:0]  cfg_pid = 6'd0;
    logic [15:0] cfg_gap = 16'd0;
    logic        lin_busy = 1'b0, comm_tx_done = 1'b0, resp_busy = 1'b0;

    logic        start, itd, frame_done, err_timeout;
    logic [5:0]  pid;
    logic [2:0]  cur_slot;
    logic [15:0] frame_cnt;
    logic        start_w, itd_w, frame_done_w, err_w;
    logic [5:0]  pid_w;
    logic [2:0]  cur_slot_w;
    logic [15:0] frame_cnt_w;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    lin_sched #(.NUM_SLOTS(8), .GAP_W(16), .TIMEOUT(4096)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .enable(enable), .last_slot(last_slot),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid), .cfg_pid(cfg_pid),
        .cfg_gap(cfg_gap), .lin_busy(lin_busy), .comm_tx_done(comm_tx_done),
        .resp_busy(resp_busy), .start(start), .pid(pid), .inter_tx_delay(itd),
        .cur_slot(cur_slot), .frame_done(frame_done), .err_timeout(err_timeout),
        .frame_cnt(frame_cnt));

    lin_sched #(.NUM_SLOTS(8), .GAP_W(16), .TIMEOUT(64)) dut_wd (
        .sys_clk(sys_clk), .rstn(rstn), .enable(enable), .last_slot(last_slot),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid), .cfg_pid(cfg_pid),
        .cfg_gap(cfg_gap), .lin_busy(lin_busy), .comm_tx_done(comm_tx_done),
        .resp_busy(resp_busy), .start(start_w), .pid(pid_w), .inter_tx_delay(itd_w),
        .cur_slot(cur_slot_w), .frame_done(frame_done_w), .err_timeout(err_w),
        .frame_cnt(frame_cnt_w));

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; last_slot = 3'd0; cfg_we = 1'b0; lin_busy = 1'b0;
        comm_tx_done = 1'b0; resp_busy = 1'b0;
        rstn = 1'b0;
        step(); step();
        rstn = 1'b1;
        step();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic v, input logic [5:0] p,
                             input logic [15:0] g);
        cfg_we = 1'b1; cfg_addr = a; cfg_valid = v; cfg_pid = p; cfg_gap = g;
        step();
        cfg_we = 1'b0;
    endtask

    // Commander handshake starting from an ISSUE cycle; ends in the first GAP cycle.
    task automatic serve_frame();
        lin_busy = 1'b1;
        step();
        comm_tx_done = 1'b1;
        step();
        comm_tx_done = 1'b0; lin_busy = 1'b0;
        step();
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (start !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        checks++;
        if ({start, pid, itd, cur_slot, frame_done, err_timeout, frame_cnt} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {start, pid, itd, cur_slot, frame_done, err_timeout, frame_cnt});
        end
        step();
        rstn = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (start !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_table_silent: start %b frame_cnt %0d expected 0 0", start, frame_cnt);
        end
    endtask

    task automatic test_schedule();
        logic [5:0] exp_pid [4];
        int n, gc;
        exp_pid[0] = 6'h01; exp_pid[1] = 6'h12; exp_pid[2] = 6'h3C; exp_pid[3] = 6'h01;
        do_reset();
        cfg_write(3'd0, 1'b1, 6'h01, 16'd10);
        cfg_write(3'd1, 1'b1, 6'h12, 16'd10);
        cfg_write(3'd2, 1'b1, 6'h3C, 16'd10);
        last_slot = 3'd2;
        enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_start(n);
            checks++;
            if (n >= 200) begin errors++; $display("FAIL sched_start_timeout: frame %0d never started", f); end
            checks++;
            if (pid !== exp_pid[f]) begin
                errors++; $display("FAIL sched_pid: frame %0d got %h expected %h", f, pid, exp_pid[f]);
            end
            lin_busy = 1'b1;
            step();
            checks++;
            if (start !== 1'b0) begin errors++; $display("FAIL sched_start_drop: got %b expected 0", start); end
            comm_tx_done = 1'b1;
            step();
            comm_tx_done = 1'b0; lin_busy = 1'b0;
            step();
            checks++;
            if (frame_done !== 1'b1 || frame_cnt !== 16'(f + 1)) begin
                errors++;
                $display("FAIL sched_frame_done: done %b cnt %0d expected 1 %0d", frame_done, frame_cnt, f + 1);
            end
            if (f == 3) enable = 1'b0;
            gc = 0;
            while (itd === 1'b1 && gc < 100) begin gc++; step(); end
            checks++;
            if (gc != 11) begin errors++; $display("FAIL sched_gap_len: got %0d expected 11", gc); end
        end
        checks++;
        if (start !== 1'b0 || cur_slot !== 3'd0 || frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL sched_idle: start %b slot %0d cnt %0d expected 0 0 4", start, cur_slot, frame_cnt);
        end
    endtask

    task automatic test_silent_slot();
        int n, k, n1, fd1, seen1;
        do_reset();
        cfg_write(3'd0, 1'b1, 6'h05, 16'd2);
        cfg_write(3'd1, 1'b0, 6'h2F, 16'd5);
        cfg_write(3'd2, 1'b1, 6'h07, 16'd2);
        last_slot = 3'd2;
        enable = 1'b1;
        wait_start(n);
        checks++;
        if (cur_slot !== 3'd0 || n >= 200) begin
            errors++; $display("FAIL silent_first_slot: slot %0d expected 0", cur_slot);
        end
        serve_frame();
        k = 0; n1 = 0; fd1 = 0; seen1 = 0;
        while (start !== 1'b1 && k < 100) begin
            if (cur_slot === 3'd1) begin
                seen1 = 1;
                if (itd === 1'b1) n1++;
                if (frame_done === 1'b1) fd1++;
            end
            step();
            k++;
        end
        checks++;
        if (seen1 != 1 || n1 != 6) begin
            errors++; $display("FAIL silent_gap: seen %0d itd cycles %0d expected 1 6", seen1, n1);
        end
        checks++;
        if (fd1 != 0) begin errors++; $display("FAIL silent_no_frame: got %0d pulses expected 0", fd1); end
        checks++;
        if (cur_slot !== 3'd2 || pid !== 6'h07 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL silent_next: slot %0d pid %h cnt %0d expected 2 07 1", cur_slot, pid, frame_cnt);
        end
        enable = 1'b0;
    endtask

    task automatic test_watchdog();
        int n, k;
        do_reset();
        cfg_write(3'd0, 1'b1, 6'h11, 16'd3);
        cfg_write(3'd1, 1'b1, 6'h22, 16'd3);
        last_slot = 3'd1;
        enable = 1'b1;
        n = 0;
        while (start_w !== 1'b1 && n < 50) begin step(); n++; end
        k = 0;
        while (err_w !== 1'b1 && k < 200) begin step(); k++; end
        // first ISSUE cycle is one after FETCH, so expiry at FETCH+64 is 63 cycles later
        checks++;
        if (k != 63) begin errors++; $display("FAIL wd_latency: got %0d expected 63", k); end
        checks++;
        if ({start_w, itd_w, frame_done_w} !== 3'b010) begin
            errors++; $display("FAIL wd_to_gap: start/itd/done %b expected 010", {start_w, itd_w, frame_done_w});
        end
        step();
        checks++;
        if (err_w !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: got %b expected 0", err_w); end
        n = 0;
        while (start_w !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (n >= 50 || cur_slot_w !== 3'd1 || pid_w !== 6'h22 || frame_cnt_w !== 16'd0) begin
            errors++;
            $display("FAIL wd_next_slot: slot %0d pid %h cnt %0d expected 1 22 0", cur_slot_w, pid_w, frame_cnt_w);
        end
        enable = 1'b0;
    endtask

    task automatic test_resp_hold();
        int n, bad;
        do_reset();
        cfg_write(3'd0, 1'b1, 6'h2A, 16'd1);
        last_slot = 3'd0;
        enable = 1'b1;
        wait_start(n);
        lin_busy = 1'b1;
        step();
        comm_tx_done = 1'b1; resp_busy = 1'b1;
        step();
        comm_tx_done = 1'b0; lin_busy = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (itd !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        checks++;
        if (n >= 200 || bad != 0) begin errors++; $display("FAIL resp_hold: %0d early gap cycles expected 0", bad); end
        resp_busy = 1'b0;
        step();
        checks++;
        if (itd !== 1'b1 || frame_done !== 1'b1 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL resp_release: itd %b done %b cnt %0d expected 1 1 1", itd, frame_done, frame_cnt);
        end
        step();
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL resp_single_pulse: got %b expected 0", frame_done); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n, gc, bad;
        do_reset();
        cfg_write(3'd0, 1'b1, 6'h15, 16'd4);
        cfg_write(3'd1, 1'b1, 6'h16, 16'd4);
        last_slot = 3'd1;
        enable = 1'b1;
        wait_start(n);
        lin_busy = 1'b1;
        step();
        enable = 1'b0;
        step(); step();
        checks++;
        if (n >= 200 || itd !== 1'b0 || start !== 1'b0) begin
            errors++; $display("FAIL drop_no_abort: itd %b start %b expected 0 0", itd, start);
        end
        comm_tx_done = 1'b1;
        step();
        comm_tx_done = 1'b0; lin_busy = 1'b0;
        step();
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL drop_frame_done: got %b expected 1", frame_done); end
        gc = 0;
        while (itd === 1'b1 && gc < 100) begin gc++; step(); end
        checks++;
        if (gc != 5) begin errors++; $display("FAIL drop_gap_len: got %0d expected 5", gc); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (start !== 1'b0 || itd !== 1'b0 || cur_slot !== 3'd0) bad++;
            step();
        end
        checks++;
        if (bad != 0 || frame_cnt !== 16'd1) begin
            errors++; $display("FAIL drop_idle: %0d bad cycles cnt %0d expected 0 1", bad, frame_cnt);
        end
    endtask

    task automatic test_async_reset();
        int n, starts, gaps;
        do_reset();
        cfg_write(3'd0, 1'b1, 6'h33, 16'd5);
        last_slot = 3'd0;
        enable = 1'b1;
        wait_start(n);
        serve_frame();
        step();
        checks++;
        if (itd !== 1'b1 || pid !== 6'h33 || frame_cnt !== 16'd1) begin
            errors++; $display("FAIL arst_precond: itd %b pid %h cnt %0d expected 1 33 1", itd, pid, frame_cnt);
        end
        rstn = 1'b0;
        #2;
        checks++;
        if ({start, pid, itd, cur_slot, frame_done, err_timeout, frame_cnt} !== 35'd0) begin
            errors++;
            $display("FAIL arst_outputs: got %h expected 0",
                     {start, pid, itd, cur_slot, frame_done, err_timeout, frame_cnt});
        end
        step(); step();
        last_slot = 3'd2;
        rstn = 1'b1;
        starts = 0; gaps = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (start === 1'b1 || frame_done === 1'b1) starts++;
            if (itd === 1'b1) gaps++;
        end
        checks++;
        if (starts != 0 || gaps == 0) begin
            errors++; $display("FAIL arst_table_cleared: starts %0d gap cycles %0d expected 0 and >0", starts, gaps);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_schedule();
        test_silent_slot();
        test_watchdog();
        test_resp_hold();
        test_enable_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
